// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Brief    : Iterative shift-add multiplier with a start/busy/done handshake and
//            a one-cycle register-file write-back request carrying the low word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signedOp,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [4:0]       rdIn,
    output logic             busy,
    output logic             done,
    output logic             wbEn,
    output logic [4:0]       wbRd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_magA;
    logic [WIDTH-1:0]       r_magB;
    logic                   r_neg;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [WIDTH-1:0]       w_magA;
    logic [WIDTH-1:0]       w_magB;
    logic                   w_neg;
    logic [2*WIDTH-1:0]     w_result;

    // Most-negative operand negates to itself, which is the correct unsigned magnitude.
    assign w_magA   = (signedOp && opA[WIDTH-1]) ? -opA : opA;
    assign w_magB   = (signedOp && opB[WIDTH-1]) ? -opB : opB;
    assign w_neg    = signedOp & (opA[WIDTH-1] ^ opB[WIDTH-1]);
    assign w_result = r_neg ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_magA  <= '0;
            r_magB  <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wbEn    <= 1'b0;
            wbRd    <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            wbEn <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_magA  <= {{WIDTH{1'b0}}, w_magA};
                        r_magB  <= w_magB;
                        r_neg   <= w_neg;
                        wbRd    <= rdIn;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Shifting the multiplicand each cycle realises magA << cnt.
                    if (r_magB[0]) begin
                        r_acc <= r_acc + r_magA;
                    end
                    r_magA <= r_magA << 1;
                    r_magB <= r_magB >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    {hi, lo} <= w_result;
                    done     <= 1'b1;
                    wbEn     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
